la_sram_sequencer: RTL

//  Sequences the logic-analyzer quad-SPI (SQI) SRAM bank: opens a write burst, clocks SAMPLE_COUNT probe samples

---
 rtl/la_sram_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/la_sram_sequencer.sv
// Logic-analyzer SQI SRAM sequencer: captures probe samples into the SRAM bank in
// one write burst, then serves them back to the MCU one per read strobe.
module la_sram_sequencer #(
  parameter int LA_WIDTH    = 8,
  parameter int LA_CHIPS    = 2,
  parameter int COUNT_WIDTH = 24,
  parameter int DUMMY_CLKS  = 2,
  parameter int CS_GAP      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] sample_count,
  input  logic                   sample_tick,
  input  logic                   rd_req,
  output logic                   rd_ack,
  output logic [LA_WIDTH-1:0]    rd_data,
  output logic                   busy,
  output logic                   capture_done,
  output logic                   sram_clk,
  output logic                   sram_cs_n,
  output logic [LA_WIDTH-1:0]    sio_out,
  output logic                   sio_oe,
  input  logic [LA_WIDTH-1:0]    sio_in,
  output logic                   lat_oe
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WCMD, ST_CAPT, ST_GAP, ST_RCMD, ST_DUMMY, ST_READ
  } state_t;

  localparam logic [7:0]             CMD_LAST   = 8'd7;
  localparam logic [7:0]             DUMMY_LAST = 8'(DUMMY_CLKS - 1);
  localparam logic [7:0]             GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = COUNT_WIDTH'(0);
  localparam logic [LA_WIDTH-1:0]    BUS_ZERO   = LA_WIDTH'(0);

  state_t                   state_r;
  logic [7:0]               bit_cnt_r;
  logic [7:0]               gap_cnt_r;
  logic [COUNT_WIDTH-1:0]   count_r;
  logic [COUNT_WIDTH-1:0]   cnt_r;
  logic                     rd_ack_r, busy_r, done_r, sclk_r, cs_n_r, sio_oe_r, lat_oe_r;
  logic [LA_WIDTH-1:0]      rd_data_r, sio_out_r;

  // Command/address nibble for bit slot idx: opcode low nibble in slot 1, zeros elsewhere.
  function automatic logic [LA_WIDTH-1:0] cmd_nibble(input logic is_read, input logic [7:0] idx);
    logic [3:0] nib;
    if (idx == 8'd1) nib = is_read ? 4'h3 : 4'h2;
    else             nib = 4'h0;
    return {LA_CHIPS{nib}};
  endfunction

  // Burst sequencer; every SRAM clock bit is a low phase followed by a high phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 8'd0;
      gap_cnt_r <= 8'd0;
      count_r   <= CNT_ZERO;
      cnt_r     <= CNT_ZERO;
      rd_ack_r  <= 1'b0;
      rd_data_r <= BUS_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      sio_out_r <= BUS_ZERO;
      sio_oe_r  <= 1'b0;
      lat_oe_r  <= 1'b0;
    end else if (abort) begin
      state_r   <= ST_IDLE;
      rd_ack_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      sio_out_r <= BUS_ZERO;
      sio_oe_r  <= 1'b0;
      lat_oe_r  <= 1'b0;
    end else begin
      rd_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (sample_count != CNT_ZERO)) begin
            state_r   <= ST_WCMD;
            count_r   <= sample_count;
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= 8'd0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            cs_n_r    <= 1'b0;
            sio_oe_r  <= 1'b1;
            sio_out_r <= cmd_nibble(1'b0, 8'd0);
          end else if (start) begin
            done_r <= 1'b1;
          end
        end
        ST_WCMD, ST_RCMD: begin
          if (!sclk_r) begin
            sclk_r <= 1'b1;
          end else if (bit_cnt_r == CMD_LAST) begin
            sclk_r    <= 1'b0;
            bit_cnt_r <= 8'd0;
            sio_oe_r  <= 1'b0;
            sio_out_r <= BUS_ZERO;
            lat_oe_r  <= (state_r == ST_WCMD);
            state_r   <= (state_r == ST_WCMD) ? ST_CAPT : ST_DUMMY;
          end else begin
            sclk_r    <= 1'b0;
            bit_cnt_r <= bit_cnt_r + 8'd1;
            sio_out_r <= cmd_nibble(state_r == ST_RCMD, bit_cnt_r + 8'd1);
          end
        end
        ST_CAPT: begin
          // A tick during the high phase cannot start a new bit and is dropped.
          if (sclk_r) begin
            sclk_r <= 1'b0;
            cnt_r  <= cnt_r + CNT_ONE;
          end else if (cnt_r == count_r) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= 8'd0;
            cs_n_r    <= 1'b1;
            lat_oe_r  <= 1'b0;
          end else if (sample_tick) begin
            sclk_r <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= ST_RCMD;
            bit_cnt_r <= 8'd0;
            done_r    <= 1'b1;
            cs_n_r    <= 1'b0;
            sio_oe_r  <= 1'b1;
            sio_out_r <= cmd_nibble(1'b1, 8'd0);
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        ST_DUMMY: begin
          if (!sclk_r) begin
            sclk_r <= 1'b1;
          end else if (bit_cnt_r == DUMMY_LAST) begin
            sclk_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_READ;
          end else begin
            sclk_r    <= 1'b0;
            bit_cnt_r <= bit_cnt_r + 8'd1;
          end
        end
        ST_READ: begin
          // The high phase doubles as the in-flight window: rd_req seen then is dropped.
          if (sclk_r) begin
            sclk_r    <= 1'b0;
            rd_data_r <= sio_in;
            rd_ack_r  <= 1'b1;
            cnt_r     <= cnt_r + CNT_ONE;
          end else if (cnt_r == count_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cs_n_r  <= 1'b1;
          end else if (rd_req) begin
            sclk_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          sclk_r   <= 1'b0;
          cs_n_r   <= 1'b1;
          sio_oe_r <= 1'b0;
          lat_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ack       = rd_ack_r;
  assign rd_data      = rd_data_r;
  assign busy         = busy_r;
  assign capture_done = done_r;
  assign sram_clk     = sclk_r;
  assign sram_cs_n    = cs_n_r;
  assign sio_out      = sio_out_r;
  assign sio_oe       = sio_oe_r;
  assign lat_oe       = lat_oe_r;

endmodule
